// File: rtl/uart_rx_if.sv
// Receive-side bundle: serial line in, word/handshake and status flags out.
// master = the receiver, slave = whoever drives the pin and consumes words.
interface uart_rx_if #(
   parameter int DWIDTH = 8
);
   logic              i_rx;
   logic              i_ready;
   logic [DWIDTH-1:0] o_data;
   logic              o_valid;
   logic              o_frame_err;
   logic              o_overrun;
   logic              o_busy;

   modport master (
      input  i_rx, i_ready,
      output o_data, o_valid, o_frame_err, o_overrun, o_busy
   );

   modport slave (
      output i_rx, i_ready,
      input  o_data, o_valid, o_frame_err, o_overrun, o_busy
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start bit, DWIDTH data bits LSB first, one stop bit, mid-bit sampling,
// received words presented on a valid/ready holding register with frame-error/overrun pulses.
module uart_rx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DWIDTH       = 8
) (
   input  logic      clk,
   input  logic      rst,
   uart_rx_if.master bus
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
   localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DWIDTH - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state;
   logic              rx_meta;
   logic              rx_s;
   logic              rx_d;
   logic [CW-1:0]     clk_cnt;
   logic [BW-1:0]     bit_idx;
   logic [DWIDTH-1:0] shift;

   // Synchroniser, bit-timing FSM and holding register share one clocked block so that
   // every output is a flop and the delivery/accept interaction is resolved in one place.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         rx_meta         <= 1'b1;
         rx_s            <= 1'b1;
         rx_d            <= 1'b1;
         clk_cnt         <= '0;
         bit_idx         <= '0;
         shift           <= '0;
         bus.o_data      <= '0;
         bus.o_valid     <= 1'b0;
         bus.o_frame_err <= 1'b0;
         bus.o_overrun   <= 1'b0;
         bus.o_busy      <= 1'b0;
      end else begin
         rx_meta         <= bus.i_rx;
         rx_s            <= rx_meta;
         rx_d            <= rx_s;
         bus.o_frame_err <= 1'b0;
         bus.o_overrun   <= 1'b0;

         if (bus.o_valid && bus.i_ready) begin
            bus.o_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (rx_d && !rx_s) begin
                  state      <= START;
                  clk_cnt    <= '0;
                  bus.o_busy <= 1'b1;
               end
            end
            START: begin
               if (clk_cnt == HALF) begin
                  if (!rx_s) begin
                     state   <= DATA;
                     clk_cnt <= '0;
                     bit_idx <= '0;
                  end else begin
                     state      <= IDLE;
                     bus.o_busy <= 1'b0;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            DATA: begin
               if (clk_cnt == LAST) begin
                  shift[bit_idx] <= rx_s;
                  clk_cnt        <= '0;
                  if (bit_idx == LAST_BIT) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + BW'(1);
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            STOP: begin
               if (clk_cnt == LAST) begin
                  state      <= IDLE;
                  clk_cnt    <= '0;
                  bus.o_busy <= 1'b0;
                  // A full register is only overwritten when the consumer takes it this cycle.
                  if (!rx_s) begin
                     bus.o_frame_err <= 1'b1;
                  end else if (!bus.o_valid || bus.i_ready) begin
                     bus.o_data  <= shift;
                     bus.o_valid <= 1'b1;
                  end else begin
                     bus.o_overrun <= 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            default: begin
               state      <= IDLE;
               bus.o_busy <= 1'b0;
            end
         endcase
      end
   end
endmodule
